i2c_lcd_slave_rx: RTL

- I2C slave receiver that emulates the LCD controller on the far end of the bus.
- Oversamples scl/sda with the system clock, detects START/STOP, matches the 7-bit slave address and ACKs accepted bytes.
- Parses the SSD1306-style control byte (Co, D/C) and emits each command/data byte with a one-cycle valid strobe.
- Sits downstream of the I2C master; consumes the master's scl/sda and drives sda low only for ACK. Used for loopback verification and as a display-model front end.

---
 rtl/i2c_lcd_slave_rx.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_lcd_slave_rx.sv
// i2c_lcd_slave_rx: write-only I2C slave that models the receive side of an
// SSD1306-style LCD controller. It oversamples scl/sda on ck, detects
// START/STOP, matches SLAVE_ADDR, ACKs accepted bytes and emits each command
// or display-data byte with a single-cycle rx_valid strobe.
// Optional build macro: I2C_RX_GLITCH_FILTER_EN adds a 3-sample agreement
// filter on both lines after the synchronizer (+2 ck detection latency).
// fsm_state mirrors the internal state register for observation.
// Handshake: rx_valid is a one-ck push strobe with no back-pressure; rx_data
// and rx_is_data are stable while it is high and hold until the next byte.
module i2c_lcd_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h3C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_is_data,
  output logic       busy,
  output logic       nack_evt,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    CTRL     = 3'd3,
    CTRL_ACK = 3'd4,
    DATA     = 3'd5,
    DATA_ACK = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_f, sda_f, scl_p, sda_p;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [6:0] sreg;
  logic [2:0] cnt;
  logic [7:0] byte_val;
  logic byte_done, addr_ok, in_shift, in_ack;
  logic ack_on, co, dc;

  // Synchronizers, preset to the idle-high bus level
  always_ff @(posedge ck) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

`ifdef I2C_RX_GLITCH_FILTER_EN
  logic [1:0] scl_h, sda_h;
  logic scl_hold, sda_hold;

  // Filtered level moves only when the current and two previous samples agree
  always_comb begin
    scl_f = scl_hold;
    sda_f = sda_hold;
    if (&{scl_h, scl_s}) scl_f = 1'b1;
    else if (~|{scl_h, scl_s}) scl_f = 1'b0;
    if (&{sda_h, sda_s}) sda_f = 1'b1;
    else if (~|{sda_h, sda_s}) sda_f = 1'b0;
  end

  // Sample history and held filter output
  always_ff @(posedge ck) begin
    if (!reset) begin
      scl_h    <= 2'b11;
      sda_h    <= 2'b11;
      scl_hold <= 1'b1;
      sda_hold <= 1'b1;
    end else begin
      scl_h    <= {scl_h[0], scl_s};
      sda_h    <= {sda_h[0], sda_s};
      scl_hold <= scl_f;
      sda_hold <= sda_f;
    end
  end
`else
  assign scl_f = scl_s;
  assign sda_f = sda_s;
`endif

  // Previous line samples for edge and START/STOP detection
  always_ff @(posedge ck) begin
    if (!reset) begin
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_p <= scl_f;
      sda_p <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_p;
  assign scl_fall  = ~scl_f & scl_p;
  assign start_det = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_det  = scl_f & scl_p & ~sda_p & sda_f;

  assign byte_val  = {sreg, sda_f};
  assign byte_done = scl_rise && (cnt == 3'd7);
  assign addr_ok   = (byte_val[7:1] == SLAVE_ADDR) && !byte_val[0];
  assign in_shift  = (state == ADDR) || (state == CTRL) || (state == DATA);
  assign in_ack    = (state == ADDR_ACK) || (state == CTRL_ACK) || (state == DATA_ACK);
  assign fsm_state = state;

  // State register
  always_ff @(posedge ck) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state; bus conditions override bit processing
  always_comb begin
    state_next = state;
    if (start_det) begin
      state_next = ADDR;
    end else if (stop_det) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     state_next = IDLE;
        ADDR:     if (byte_done) state_next = addr_ok ? ADDR_ACK : IGNORE;
        ADDR_ACK: if (scl_fall && ack_on) state_next = CTRL;
        CTRL:     if (byte_done) state_next = CTRL_ACK;
        CTRL_ACK: if (scl_fall && ack_on) state_next = DATA;
        DATA:     if (byte_done) state_next = DATA_ACK;
        DATA_ACK: if (scl_fall && ack_on) state_next = co ? CTRL : DATA;
        IGNORE:   state_next = IGNORE;
        default:  state_next = IDLE;
      endcase
    end
  end

  // Shift register, control-byte flags, ACK drive and output strobes
  always_ff @(posedge ck) begin
    if (!reset) begin
      sreg       <= '0;
      cnt        <= '0;
      sda_oe     <= 1'b0;
      ack_on     <= 1'b0;
      co         <= 1'b0;
      dc         <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_is_data <= 1'b0;
      busy       <= 1'b0;
      nack_evt   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      nack_evt <= 1'b0;
      if (start_det || stop_det) begin
        // Any partial byte is dropped and the ACK slot is abandoned
        sreg   <= '0;
        cnt    <= '0;
        sda_oe <= 1'b0;
        ack_on <= 1'b0;
        busy   <= 1'b0;
      end else begin
        if (in_shift && scl_rise) begin
          sreg <= byte_val[6:0];
          cnt  <= cnt + 3'd1;
        end
        if (byte_done) begin
          case (state)
            ADDR: begin
              if (addr_ok) busy <= 1'b1;
              else         nack_evt <= 1'b1;
            end
            CTRL: begin
              co <= byte_val[7];
              dc <= byte_val[6];
            end
            DATA: begin
              rx_data    <= byte_val;
              rx_is_data <= dc;
              rx_valid   <= 1'b1;
            end
            default: ;
          endcase
        end
        // First SCL fall of the slot pulls SDA low, the second releases it
        if (in_ack && scl_fall) begin
          sda_oe <= ~ack_on;
          ack_on <= ~ack_on;
        end
      end
    end
  end

endmodule
